// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding and nominal timing constants.
package pwm_capture_pkg;

  localparam int PWM_PERIOD_CYCLES = 16000;
  localparam int CLK_HZ            = 16000000;

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// Synchronizer chain plus one history flop; emits level and single-cycle rise/fall strobes.
module pwm_capture_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   w_sync;
  logic                   w_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until the chain and history flop hold real samples, so a line
  // that is already high at reset release does not look like a fresh rise.
  assign w_armed = r_fill[SYNC_STAGES];
  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_sync  = w_sync;
  assign o_rise  = w_armed &  w_sync & ~r_prev;
  assign o_fall  = w_armed & ~w_sync &  r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in clock cycles,
// with a one-cycle valid strobe and a dead-line timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 32000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_enable,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_high_time,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_level
);

  localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_END  = IDLE_W'(TIMEOUT);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_high_cnt, w_high_cnt_nxt;
  logic [CNT_W-1:0]  r_per_cnt, w_per_cnt_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [CNT_W-1:0]  r_high_time, w_high_time_nxt;
  logic [CNT_W-1:0]  r_period, w_period_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              w_sync, w_rise, w_fall, w_edge, w_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  pwm_capture_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_enable),
    .i_d     (i_pwm_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge i_clk or negedge i_enable) begin
    if (!i_enable) begin
      r_state     <= ST_SEEK;
      r_high_cnt  <= '0;
      r_per_cnt   <= '0;
      r_idle_cnt  <= '0;
      r_high_time <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_high_cnt  <= w_high_cnt_nxt;
      r_per_cnt   <= w_per_cnt_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_high_time <= w_high_time_nxt;
      r_period    <= w_period_nxt;
      r_valid     <= w_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign w_edge = w_rise | w_fall;
  // An edge on the very cycle the idle count would expire wins over the timeout.
  assign w_fire = ~w_edge && (r_idle_cnt == IDLE_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_high_cnt_nxt  = r_high_cnt;
    w_per_cnt_nxt   = r_per_cnt;
    w_high_time_nxt = r_high_time;
    w_period_nxt    = r_period;
    w_valid_nxt     = 1'b0;
    w_timeout_nxt   = r_timeout;
    w_idle_cnt_nxt  = w_edge ? '0 :
                      (r_idle_cnt == IDLE_END) ? r_idle_cnt : r_idle_cnt + 1'b1;

    case (r_state)
      ST_SEEK: begin
        if (w_rise) begin
          w_high_cnt_nxt = CNT_ONE;
          w_per_cnt_nxt  = CNT_ONE;
          w_state_nxt    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        w_per_cnt_nxt = sat_inc(r_per_cnt);
        if (w_fall) w_state_nxt = ST_LOW;
        else        w_high_cnt_nxt = sat_inc(r_high_cnt);
      end
      ST_LOW: begin
        if (w_rise) begin
          w_high_time_nxt = r_high_cnt;
          w_period_nxt    = r_per_cnt;
          w_valid_nxt     = 1'b1;
          w_timeout_nxt   = 1'b0;
          w_high_cnt_nxt  = CNT_ONE;
          w_per_cnt_nxt   = CNT_ONE;
          w_state_nxt     = ST_HIGH;
        end else begin
          w_per_cnt_nxt = sat_inc(r_per_cnt);
        end
      end
      default: w_state_nxt = ST_SEEK;
    endcase

    if (w_fire) begin
      w_timeout_nxt   = 1'b1;
      w_high_time_nxt = '0;
      w_period_nxt    = '0;
      w_valid_nxt     = 1'b0;
      w_state_nxt     = ST_SEEK;
    end
  end

  assign o_high_time = r_high_time;
  assign o_period    = r_period;
  assign o_valid     = r_valid;
  assign o_timeout   = r_timeout;
  assign o_level     = w_sync;

endmodule
